// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU op codes, MIPS opcode/funct values
// and the decoded-entry record carried through the issue buffer.
package alu_issue_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store_data;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
  } entry_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS-I decode of an instruction plus its register operands into one
// issue entry (ALU code, operands, writeback and memory flags).
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output entry_t      entry
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [4:0]  unused_rs;
  logic        bad;

  assign op        = instr[31:26];
  assign unused_rs = instr[25:21];  // rs is already resolved into rs_val by register-read
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign imm       = instr[15:0];

  always_comb begin
    entry            = '0;
    bad              = 1'b0;
    entry.store_data = rt_val;
    entry.a          = rs_val;
    if (op == OP_RTYPE) begin
      entry.b      = rt_val;
      entry.wr_reg = rd;
      entry.wr_en  = (rd != 5'd0);
      case (funct)
        F_ADD, F_ADDU: entry.alu_ctrl = ALU_ADD;
        F_SUB, F_SUBU: entry.alu_ctrl = ALU_SUB;
        F_AND:         entry.alu_ctrl = ALU_AND;
        F_OR:          entry.alu_ctrl = ALU_OR;
        F_XOR:         entry.alu_ctrl = ALU_XOR;
        F_NOR:         entry.alu_ctrl = ALU_NOR;
        F_SLT:         entry.alu_ctrl = ALU_SLT;
        F_SLTU:        entry.alu_ctrl = ALU_SLTU;
        F_SLL: begin entry.alu_ctrl = ALU_SLL; entry.a = {27'b0, shamt}; end
        F_SRL: begin entry.alu_ctrl = ALU_SRL; entry.a = {27'b0, shamt}; end
        F_SRA: begin entry.alu_ctrl = ALU_SRA; entry.a = {27'b0, shamt}; end
        F_SLLV:        entry.alu_ctrl = ALU_SLL;
        F_SRLV:        entry.alu_ctrl = ALU_SRL;
        F_SRAV:        entry.alu_ctrl = ALU_SRA;
        default:       bad = 1'b1;
      endcase
    end else begin
      entry.wr_reg = rt;
      entry.wr_en  = (rt != 5'd0);
      entry.b      = sign_ext16(imm);
      case (op)
        OP_ADDI, OP_ADDIU: entry.alu_ctrl = ALU_ADD;
        OP_SLTI:           entry.alu_ctrl = ALU_SLT;
        OP_SLTIU:          entry.alu_ctrl = ALU_SLTU;
        OP_ANDI: begin entry.alu_ctrl = ALU_AND; entry.b = {16'b0, imm}; end
        OP_ORI:  begin entry.alu_ctrl = ALU_OR;  entry.b = {16'b0, imm}; end
        OP_XORI: begin entry.alu_ctrl = ALU_XOR; entry.b = {16'b0, imm}; end
        OP_LUI: begin
          entry.alu_ctrl = ALU_LUI;
          entry.a        = '0;
          entry.b        = {16'b0, imm};
        end
        OP_LW: begin entry.alu_ctrl = ALU_ADD; entry.mem_rd = 1'b1; end
        OP_SW: begin
          entry.alu_ctrl = ALU_ADD;
          entry.mem_wr   = 1'b1;
          entry.wr_en    = 1'b0;
        end
        default: bad = 1'b1;
      endcase
    end
    // Unknown encodings still flow downstream as a harmless ADD 0,0 tagged illegal.
    if (bad) begin
      entry.alu_ctrl = ALU_ADD;
      entry.a        = '0;
      entry.b        = '0;
      entry.wr_en    = 1'b0;
      entry.wr_reg   = '0;
      entry.mem_rd   = 1'b0;
      entry.mem_wr   = 1'b0;
      entry.illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes before capture, then holds entries in a main register plus an
// optional skid register so in_ready can come straight from a flop.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DW   = 32,
  parameter bit SKID = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_val,
  input  logic [DW-1:0] rt_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] store_data,
  output logic          wr_en,
  output logic [4:0]    wr_reg,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and outputs hold steady while out_valid && !out_ready.

  entry_t dec;
  entry_t main_q, main_nxt;
  entry_t skid_q, skid_nxt;
  logic   main_valid, main_v_nxt;
  logic   skid_valid, skid_v_nxt;
  logic   in_ready_q;
  logic   in_fire, out_fire;

  alu_issue_decode u_decode (
    .instr  (instr),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .entry  (dec)
  );

  assign in_ready = SKID ? in_ready_q : (!main_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

  always_comb begin
    main_nxt   = main_q;
    skid_nxt   = skid_q;
    main_v_nxt = main_valid;
    skid_v_nxt = skid_valid;
    if (flush) begin
      main_v_nxt = 1'b0;
      skid_v_nxt = 1'b0;
    end else if (out_fire) begin
      if (skid_valid) begin
        main_nxt   = skid_q;
        skid_v_nxt = 1'b0;
      end else if (in_fire) begin
        main_nxt = dec;
      end else begin
        main_v_nxt = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid) begin
        main_nxt   = dec;
        main_v_nxt = 1'b1;
      end else begin
        skid_nxt   = dec;
        skid_v_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_nxt;
      skid_q     <= skid_nxt;
      main_valid <= main_v_nxt;
      skid_valid <= skid_v_nxt;
      in_ready_q <= !skid_v_nxt;
    end
  end

  assign out_valid  = main_valid;
  assign alu_ctrl   = main_q.alu_ctrl;
  assign alu_a      = main_q.a;
  assign alu_b      = main_q.b;
  assign store_data = main_q.store_data;
  assign wr_en      = main_q.wr_en;
  assign wr_reg     = main_q.wr_reg;
  assign mem_rd     = main_q.mem_rd;
  assign mem_wr     = main_q.mem_wr;
  assign illegal    = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed MIPS cases, stall/flush/reset scenarios and a random
// stream, all checked against a queue-based reference model of a 2-deep in-order buffer.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        we;
    logic [4:0]  wr;
    logic        mr;
    logic        mw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, store_data;
  logic        wr_en, mem_rd, mem_wr, illegal;
  logic [4:0]  wr_reg;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  logic [5:0] r_functs[16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] i_ops[10] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                            6'h23, 6'h2B};

  alu_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .store_data (store_data),
    .wr_en      (wr_en),
    .wr_reg     (wr_reg),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .illegal    (illegal)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference decode, written from the instruction-set rules with literal op codes.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                      input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] simm, zimm;
    logic        shift_imm;
    op   = ins[31:26];
    fn   = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0000, ins[15:0]};
    e    = '0;
    e.sd = rt;
    shift_imm = 1'b0;
    if (op == 6'h00) begin
      e.wr = ins[15:11];
      e.we = (ins[15:11] != 0);
      case (fn)
        6'h20, 6'h21: e.ctrl = 4'd0;
        6'h22, 6'h23: e.ctrl = 4'd1;
        6'h24: e.ctrl = 4'd2;
        6'h25: e.ctrl = 4'd3;
        6'h26: e.ctrl = 4'd4;
        6'h27: e.ctrl = 4'd5;
        6'h2A: e.ctrl = 4'd9;
        6'h2B: e.ctrl = 4'd10;
        6'h00: begin e.ctrl = 4'd6; shift_imm = 1'b1; end
        6'h02: begin e.ctrl = 4'd7; shift_imm = 1'b1; end
        6'h03: begin e.ctrl = 4'd8; shift_imm = 1'b1; end
        6'h04: e.ctrl = 4'd6;
        6'h06: e.ctrl = 4'd7;
        6'h07: e.ctrl = 4'd8;
        default: e.ill = 1'b1;
      endcase
      e.a = shift_imm ? 32'(ins[10:6]) : rs;
      e.b = rt;
    end else begin
      e.wr = ins[20:16];
      e.we = (ins[20:16] != 0);
      e.a  = rs;
      case (op)
        6'h08, 6'h09: begin e.ctrl = 4'd0;  e.b = simm; end
        6'h0A:        begin e.ctrl = 4'd9;  e.b = simm; end
        6'h0B:        begin e.ctrl = 4'd10; e.b = simm; end
        6'h0C:        begin e.ctrl = 4'd2;  e.b = zimm; end
        6'h0D:        begin e.ctrl = 4'd3;  e.b = zimm; end
        6'h0E:        begin e.ctrl = 4'd4;  e.b = zimm; end
        6'h0F:        begin e.ctrl = 4'd11; e.a = 0; e.b = zimm; end
        6'h23:        begin e.ctrl = 4'd0;  e.b = simm; e.mr = 1'b1; end
        6'h2B:        begin e.ctrl = 4'd0;  e.b = simm; e.mw = 1'b1; e.we = 1'b0; end
        default:      e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e.ctrl = 4'd0; e.a = 0; e.b = 0; e.we = 0; e.mr = 0; e.mw = 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare DUT outputs with the head of the expected queue
  task automatic check_state(input string tag);
    exp_t e;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(e.ctrl));
      chk({tag, ".alu_a"}, alu_a, e.a);
      chk({tag, ".alu_b"}, alu_b, e.b);
      chk({tag, ".wr_en"}, 32'(wr_en), 32'(e.we));
      chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(e.mr));
      chk({tag, ".mem_wr"}, 32'(mem_wr), 32'(e.mw));
      chk({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
      if (e.we) chk({tag, ".wr_reg"}, 32'(wr_reg), 32'(e.wr));
      if (e.mw) chk({tag, ".store_data"}, store_data, e.sd);
    end
  endtask

  // driver: one clock of stimulus, called just after a falling edge
  task automatic step(input string tag, input logic iv, input logic [31:0] ins,
                      input logic [31:0] rs, input logic [31:0] rt, input logic ordy,
                      input logic fl, output logic acc);
    logic ofire;
    exp_t e;
    in_valid  = iv;
    instr     = ins;
    rs_val    = rs;
    rt_val    = rt;
    out_ready = ordy;
    flush     = fl;
    acc       = iv && (exp_q.size() < 2);
    ofire     = ordy && (exp_q.size() > 0);
    e         = ref_decode(ins, rs, rt);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      acc = 1'b0;
    end else begin
      if (ofire) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check_state(tag);
  endtask

  function automatic logic [31:0] gen_instr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 4)
      return {6'h00, 5'($urandom), 5'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
              5'($urandom), r_functs[$urandom_range(0, 15)]};
    else if (sel < 8)
      return {i_ops[$urandom_range(0, 9)], 26'($urandom)};
    else
      return $urandom;
  endfunction

  initial begin
    logic        acc;
    int          idx;
    int          emitted;
    logic        saw_stall;
    logic [31:0] s_ins[4];

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.alu_a", alu_a, 32'd0);
    chk("reset.alu_b", alu_b, 32'd0);
    chk("reset.alu_ctrl", 32'(alu_ctrl), 32'd0);
    rst_n = 1'b1;

    // directed decode cases with the consumer always ready
    step("addu", 1'b1, 32'h00221821, 32'd5, 32'd7, 1'b1, 1'b0, acc);
    chk("addu.ctrl", 32'(alu_ctrl), 32'h0);
    chk("addu.a", alu_a, 32'd5);
    chk("addu.b", alu_b, 32'd7);
    chk("addu.wr_reg", 32'(wr_reg), 32'd3);
    chk("addu.wr_en", 32'(wr_en), 32'd1);
    step("sra", 1'b1, 32'h000520C3, 32'h0, 32'h80000000, 1'b1, 1'b0, acc);
    chk("sra.ctrl", 32'(alu_ctrl), 32'h8);
    chk("sra.a", alu_a, 32'd3);
    chk("sra.b", alu_b, 32'h80000000);
    step("ori", 1'b1, 32'h3406FFFF, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    chk("ori.ctrl", 32'(alu_ctrl), 32'h3);
    chk("ori.b", alu_b, 32'h0000FFFF);
    step("lui", 1'b1, 32'h3C071234, 32'h55, 32'h0, 1'b1, 1'b0, acc);
    chk("lui.ctrl", 32'(alu_ctrl), 32'hB);
    chk("lui.a", alu_a, 32'h0);
    chk("lui.b", alu_b, 32'h00001234);
    step("sw", 1'b1, 32'hAC22FFFC, 32'h100, 32'hCAFE, 1'b1, 1'b0, acc);
    chk("sw.ctrl", 32'(alu_ctrl), 32'h0);
    chk("sw.b", alu_b, 32'hFFFFFFFC);
    chk("sw.mem_wr", 32'(mem_wr), 32'd1);
    chk("sw.wr_en", 32'(wr_en), 32'd0);
    chk("sw.store_data", store_data, 32'hCAFE);
    step("funct3f", 1'b1, 32'h0022183F, 32'h9, 32'h9, 1'b1, 1'b0, acc);
    chk("funct3f.illegal", 32'(illegal), 32'd1);
    chk("funct3f.wr_en", 32'(wr_en), 32'd0);
    chk("funct3f.ctrl", 32'(alu_ctrl), 32'h0);
    step("op3f", 1'b1, 32'hFC000000, 32'h9, 32'h9, 1'b1, 1'b0, acc);
    chk("op3f.illegal", 32'(illegal), 32'd1);
    step("addu_rd0", 1'b1, 32'h00220021, 32'd1, 32'd2, 1'b1, 1'b0, acc);
    chk("addu_rd0.wr_en", 32'(wr_en), 32'd0);
    chk("addu_rd0.illegal", 32'(illegal), 32'd0);
    step("drain", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // stream of 4 with out_ready low on cycles 2-3
    s_ins = '{32'h00221821, 32'h00432020, 32'h00642822, 32'h00853024};
    idx = 0;
    emitted = 0;
    saw_stall = 1'b0;
    for (int c = 1; c <= 20 && (idx < 4 || exp_q.size() > 0); c++) begin
      logic ordy;
      ordy = !(c == 2 || c == 3);
      if (ordy && exp_q.size() > 0) emitted++;
      step($sformatf("stream%0d", c), idx < 4, s_ins[idx & 3], 32'(c * 16), 32'(c), ordy,
           1'b0, acc);
      if (acc) idx++;
      if (!in_ready) saw_stall = 1'b1;
    end
    chk("stream.accepted", 32'(idx), 32'd4);
    chk("stream.emitted", 32'(emitted), 32'd4);
    chk("stream.saw_stall", 32'(saw_stall), 32'd1);
    chk("stream.drained", 32'(exp_q.size()), 32'd0);

    // flush with both entries full and a new instruction offered
    step("fill0", 1'b1, 32'h3C010001, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    step("fill1", 1'b1, 32'h3C020002, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    chk("fill.full", 32'(in_ready), 32'd0);
    step("flush", 1'b1, 32'h3C030003, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    step("post_flush", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    step("post_flush2", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // flush coinciding with an in transfer on an empty stage: the new entry is dropped too
    step("flush_in", 1'b1, 32'h3C040004, 32'h0, 32'h0, 1'b1, 1'b1, acc);

    // asynchronous reset pulse in the middle of a stall
    step("stall0", 1'b1, 32'h24050007, 32'h1, 32'h0, 1'b0, 1'b0, acc);
    step("stall1", 1'b1, 32'h24060008, 32'h2, 32'h0, 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.in_ready", 32'(in_ready), 32'd1);
    chk("async_rst.alu_b", alu_b, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_state("after_rst");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rs, rt;
      rs = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      rt = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
      step("rand", $urandom_range(0, 3) != 0, gen_instr(), rs, rt,
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
